// File: rtl/hazard_tnew_pipeline_pkg.sv
// Shared constants and types for the Tnew tracking pipeline.
package hazard_tnew_pipeline_pkg;

    // Forwarding source for an ID-stage operand
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // Tnew an instruction carries when it enters EX
    localparam int TNEW_LOAD = 2;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LINK = 0;

    // Destination value of a bubble; WA=0 means "no producer"
    localparam int BUBBLE_WA = 0;

endpackage

// File: rtl/hazard_tnew_pipeline_if.sv
// ID-stage inputs and tracked-state outputs of hazard_tnew_pipeline.
// The counters exist only when HAZARD_STALL_CNT_EN is defined.
interface hazard_tnew_pipeline_if #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
);
    logic              Stall;
    logic              Flush;
    logic [ADDR_W-1:0] WA_ID;
    logic [TNEW_W-1:0] Tnew_ID;
    logic [ADDR_W-1:0] RA1_ID;
    logic [ADDR_W-1:0] RA2_ID;

    logic [ADDR_W-1:0] WA_EX;
    logic [ADDR_W-1:0] WA_MEM;
    logic [ADDR_W-1:0] WA_WB;
    logic [TNEW_W-1:0] Tnew_EX;
    logic [TNEW_W-1:0] Tnew_MEM;
    logic [TNEW_W-1:0] Tnew_WB;
    logic [1:0]        FwdSel_RA1;
    logic [1:0]        FwdSel_RA2;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0]       StallCnt;
    logic [31:0]       BubbleCnt;

    modport master (
        output Stall, Flush, WA_ID, Tnew_ID, RA1_ID, RA2_ID,
        input  WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB,
        input  FwdSel_RA1, FwdSel_RA2, StallCnt, BubbleCnt
    );
    modport slave (
        input  Stall, Flush, WA_ID, Tnew_ID, RA1_ID, RA2_ID,
        output WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB,
        output FwdSel_RA1, FwdSel_RA2, StallCnt, BubbleCnt
    );
`else
    modport master (
        output Stall, Flush, WA_ID, Tnew_ID, RA1_ID, RA2_ID,
        input  WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB,
        input  FwdSel_RA1, FwdSel_RA2
    );
    modport slave (
        input  Stall, Flush, WA_ID, Tnew_ID, RA1_ID, RA2_ID,
        output WA_EX, WA_MEM, WA_WB, Tnew_EX, Tnew_MEM, Tnew_WB,
        output FwdSel_RA1, FwdSel_RA2
    );
`endif

endinterface

// File: rtl/hazard_tnew_pipeline_fwd_select.sv
// Combinational forwarding select for one ID-stage source register.
// Only the youngest stage whose WA matches may be chosen; if that stage
// has not produced its result yet, the operand is left on the register
// file and the stall generator is expected to hold ID.
module hazard_tnew_pipeline_fwd_select
    import hazard_tnew_pipeline_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] wa_ex_i,
    input  logic [TNEW_W-1:0] tnew_ex_i,
    input  logic [ADDR_W-1:0] wa_mem_i,
    input  logic [TNEW_W-1:0] tnew_mem_i,
    input  logic [ADDR_W-1:0] wa_wb_i,
    input  logic [TNEW_W-1:0] tnew_wb_i,
    output fwd_sel_e          sel_o
);

    // Youngest matching producer decides; r0 never forwards
    always_comb begin
        sel_o = FWD_RF;
        if (ra_i != '0) begin
            if (wa_ex_i == ra_i) begin
                sel_o = (tnew_ex_i == '0) ? FWD_EX : FWD_RF;
            end else if (wa_mem_i == ra_i) begin
                sel_o = (tnew_mem_i == '0) ? FWD_MEM : FWD_RF;
            end else if (wa_wb_i == ra_i) begin
                sel_o = (tnew_wb_i == '0) ? FWD_WB : FWD_RF;
            end
        end
    end

endmodule

// File: rtl/hazard_tnew_pipeline.sv
// Tracks destination register and Tnew of each in-flight instruction
// through EX/MEM/WB and derives ID-stage forwarding selects.
// Optional: define HAZARD_STALL_CNT_EN to add StallCnt/BubbleCnt.
module hazard_tnew_pipeline
    import hazard_tnew_pipeline_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_tnew_pipeline_if.slave   bus
);

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    logic [ADDR_W-1:0] wa_ex_q,   wa_ex_d;
    logic [TNEW_W-1:0] tnew_ex_q, tnew_ex_d;
    logic [ADDR_W-1:0] wa_mem_q,   wa_mem_d;
    logic [TNEW_W-1:0] tnew_mem_q, tnew_mem_d;
    logic [ADDR_W-1:0] wa_wb_q,   wa_wb_d;
    logic [TNEW_W-1:0] tnew_wb_q, tnew_wb_d;
    logic              bubble;

    assign bubble = bus.Stall | bus.Flush;

    // Next stage contents: EX takes ID or a bubble, older stages shift and age
    always_comb begin
        wa_ex_d    = bubble ? ADDR_W'(BUBBLE_WA) : bus.WA_ID;
        tnew_ex_d  = bubble ? '0 : bus.Tnew_ID;
        wa_mem_d   = wa_ex_q;
        tnew_mem_d = sat_dec(tnew_ex_q);
        wa_wb_d    = wa_mem_q;
        tnew_wb_d  = sat_dec(tnew_mem_q);
    end

    // Stage registers advance every cycle; reset empties the whole pipe
    always_ff @(posedge clk) begin
        if (reset) begin
            wa_ex_q    <= '0;
            tnew_ex_q  <= '0;
            wa_mem_q   <= '0;
            tnew_mem_q <= '0;
            wa_wb_q    <= '0;
            tnew_wb_q  <= '0;
        end else begin
            wa_ex_q    <= wa_ex_d;
            tnew_ex_q  <= tnew_ex_d;
            wa_mem_q   <= wa_mem_d;
            tnew_mem_q <= tnew_mem_d;
            wa_wb_q    <= wa_wb_d;
            tnew_wb_q  <= tnew_wb_d;
        end
    end

    assign bus.WA_EX    = wa_ex_q;
    assign bus.WA_MEM   = wa_mem_q;
    assign bus.WA_WB    = wa_wb_q;
    assign bus.Tnew_EX  = tnew_ex_q;
    assign bus.Tnew_MEM = tnew_mem_q;
    assign bus.Tnew_WB  = tnew_wb_q;

    fwd_sel_e sel_ra1;
    fwd_sel_e sel_ra2;

    hazard_tnew_pipeline_fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_ra1 (
        .ra_i       (bus.RA1_ID),
        .wa_ex_i    (wa_ex_q),
        .tnew_ex_i  (tnew_ex_q),
        .wa_mem_i   (wa_mem_q),
        .tnew_mem_i (tnew_mem_q),
        .wa_wb_i    (wa_wb_q),
        .tnew_wb_i  (tnew_wb_q),
        .sel_o      (sel_ra1)
    );

    hazard_tnew_pipeline_fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_ra2 (
        .ra_i       (bus.RA2_ID),
        .wa_ex_i    (wa_ex_q),
        .tnew_ex_i  (tnew_ex_q),
        .wa_mem_i   (wa_mem_q),
        .tnew_mem_i (tnew_mem_q),
        .wa_wb_i    (wa_wb_q),
        .tnew_wb_i  (tnew_wb_q),
        .sel_o      (sel_ra2)
    );

    assign bus.FwdSel_RA1 = sel_ra1;
    assign bus.FwdSel_RA2 = sel_ra2;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Event counters wrap naturally at 2^32
    always_comb begin
        stall_cnt_d  = stall_cnt_q  + (bus.Stall ? 32'd1 : 32'd0);
        bubble_cnt_d = bubble_cnt_q + (bubble    ? 32'd1 : 32'd0);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.StallCnt  = stall_cnt_q;
    assign bus.BubbleCnt = bubble_cnt_q;
`endif

endmodule
